// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, ALU op
// classes, ALU function codes, opcodes and datapath select values.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_e;

    typedef enum logic [1:0] {
        ALUOP_ADD  = 2'b00,
        ALUOP_SUB  = 2'b01,
        ALUOP_FUNC = 2'b10
    } alu_op_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_STORE:  imm_src_of = IMM_S;
            OP_BRANCH: imm_src_of = IMM_B;
            OP_JAL:    imm_src_of = IMM_J;
            default:   imm_src_of = IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// ALU decoder: maps the FSM's ALU op class plus funct3/funct7[5]/op[5] onto
// the ALU function code; bits above [2:0] are tied to zero.
module mc_alu_dec import ctrl_pkg::*; #(
    parameter int ALU_CTRL_W = 3
) (
    input  alu_op_e               alu_op,
    input  logic [2:0]            funct3,
    input  logic                  funct7_5,
    input  logic                  op_5,
    output logic [ALU_CTRL_W-1:0] alu_control
);

    logic [2:0] code;

    always_comb begin
        code = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: code = ALU_SUB;
            ALUOP_FUNC: begin
                case (funct3)
                    3'b000:  code = (op_5 && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b001:  code = ALU_SLL;
                    3'b010:  code = ALU_SLT;
                    3'b100:  code = ALU_XOR;
                    3'b101:  code = ALU_SRL;
                    3'b110:  code = ALU_OR;
                    3'b111:  code = ALU_AND;
                    default: code = ALU_ADD;
                endcase
            end
            default: code = ALU_ADD;
        endcase
        alu_control = ALU_CTRL_W'(code);
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore-style FSM controller for the multicycle RV32I datapath with memory
// handshake and bounded wait. Define BRANCH_EXT_EN for the full branch set.
module multicycle_control_unit import ctrl_pkg::*; #(
    parameter int ALU_CTRL_W = 3,
    parameter int WAIT_LIMIT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            op,
    input  logic [2:0]            funct3,
    input  logic                  funct7_5,
    input  logic                  zero,
    input  logic                  lt,
    input  logic                  ltu,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  mem_write,
    output logic                  adr_src,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  reg_write,
    output logic [1:0]            result_src,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            imm_src,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  illegal_op,
    output logic                  mem_timeout
);

    localparam int CNT_W = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    alu_op_e          alu_op;
    logic             waiting, expired, taken;
    logic             mem_req_raw, mem_write_raw, ir_write_raw;
    logic             pc_write_raw, reg_write_raw, illegal_raw;

`ifdef BRANCH_EXT_EN
    always_comb begin
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = lt;
            3'b101:  taken = !lt;
            3'b110:  taken = ltu;
            3'b111:  taken = !ltu;
            default: taken = 1'b0;
        endcase
    end
`else
    logic unused_branch_flags;
    assign unused_branch_flags = lt ^ ltu;
    assign taken = zero;
`endif

    assign waiting = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
    assign expired = (WAIT_LIMIT > 0) && waiting && !mem_ready && (wait_cnt_q == LIMIT);
    assign wait_cnt_d = (waiting && !mem_ready && !expired) ? wait_cnt_q + 1'b1 : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        mem_req_raw   = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        pc_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        illegal_raw   = 1'b0;
        adr_src       = 1'b0;
        result_src    = RES_ALUOUT;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        alu_op        = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                mem_req_raw = 1'b1;
                alu_src_b   = SRCB_FOUR;
                result_src  = RES_ALURESULT;
                if (mem_ready) begin
                    ir_write_raw = 1'b1;
                    pc_write_raw = 1'b1;
                    state_d      = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                state_d   = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req_raw = 1'b1;
                adr_src     = 1'b1;
                if (mem_ready)    state_d = S_MEMWB;
                else if (expired) state_d = S_FETCH;
            end
            S_MEMWB: begin
                result_src    = RES_DATA;
                reg_write_raw = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req_raw   = 1'b1;
                mem_write_raw = 1'b1;
                adr_src       = 1'b1;
                if (mem_ready || expired) state_d = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALUOP_FUNC;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNC;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
                state_d       = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a    = SRCA_RS1;
                alu_op       = ALUOP_SUB;
                pc_write_raw = taken;
                state_d      = S_FETCH;
            end
            S_JAL: begin
                // ALUResult carries OldPC+4 so ALUWB can write the link register.
                alu_src_a    = SRCA_OLDPC;
                alu_src_b    = SRCB_FOUR;
                pc_write_raw = 1'b1;
                state_d      = S_ALUWB;
            end
            S_ILLEGAL: begin
                illegal_raw = 1'b1;
                state_d     = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    mc_alu_dec #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_dec (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7_5    (funct7_5),
        .op_5        (op[5]),
        .alu_control (alu_control)
    );

    // Enables are forced low during reset even though FETCH would assert them.
    assign mem_req     = rst_n & mem_req_raw;
    assign mem_write   = rst_n & mem_write_raw;
    assign ir_write    = rst_n & ir_write_raw;
    assign pc_write    = rst_n & pc_write_raw;
    assign reg_write   = rst_n & reg_write_raw;
    assign illegal_op  = rst_n & illegal_raw;
    assign mem_timeout = rst_n & expired;
    assign imm_src     = imm_src_of(op);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit: drives instruction fields and
// memory handshakes, comparing every output against a phase-level model.
module tb_multicycle_control_unit;

    localparam int ALU_CTRL_W = 3;
    localparam int WAIT_LIMIT = 15;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] RTYPE  = 7'b0110011;
    localparam logic [6:0] ITYPE  = 7'b0010011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] LUI    = 7'b0110111;

    logic clk, rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic funct7_5, zero, lt, ltu, mem_ready;
    logic mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [ALU_CTRL_W-1:0] alu_control;
    logic illegal_op, mem_timeout;

    int errors = 0;
    int checks = 0;

    typedef enum {P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
                  P_EXECR, P_EXECI, P_ALUWB, P_BRANCH, P_JAL, P_ILLEGAL} phase_t;
    phase_t phase = P_FETCH;
    int waitCount = 0;

    multicycle_control_unit #(.ALU_CTRL_W(ALU_CTRL_W), .WAIT_LIMIT(WAIT_LIMIT)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7_5(funct7_5),
        .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .imm_src(imm_src), .alu_control(alu_control),
        .illegal_op(illegal_op), .mem_timeout(mem_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (phase %s)", tag, observed, expected, phase.name());
        end
    endtask

    // Function codes: ADD=0 SUB=1 AND=2 OR=3 XOR=4 SLT=5 SLL=6 SRL=7.
    function automatic int funcCode(input logic [6:0] o, input logic [2:0] f3, input logic f75);
        int table3[8] = '{0, 6, 5, 0, 4, 7, 3, 2};
        if (f3 == 3'd0 && o[5] && f75) return 1;
        return table3[f3];
    endfunction

    function automatic int immOf(input logic [6:0] o);
        if (o == STORE)  return 1;
        if (o == BRANCH) return 2;
        if (o == JAL)    return 3;
        return 0;
    endfunction

    function automatic bit branchTaken(input logic [2:0] f3, input logic z, input logic l, input logic lu);
`ifdef BRANCH_EXT_EN
        case (f3)
            3'd0: return z;
            3'd1: return !z;
            3'd4: return l;
            3'd5: return !l;
            3'd6: return lu;
            3'd7: return !lu;
            default: return 1'b0;
        endcase
`else
        return z;
`endif
    endfunction

    task automatic applyReset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        phase = P_FETCH;
        waitCount = 0;
        checkOutput("rst mem_req", 8'(mem_req), 8'd0);
        checkOutput("rst mem_write", 8'(mem_write), 8'd0);
        checkOutput("rst ir_write", 8'(ir_write), 8'd0);
        checkOutput("rst pc_write", 8'(pc_write), 8'd0);
        checkOutput("rst reg_write", 8'(reg_write), 8'd0);
        checkOutput("rst illegal_op", 8'(illegal_op), 8'd0);
        checkOutput("rst mem_timeout", 8'(mem_timeout), 8'd0);
        checkOutput("rst adr_src", 8'(adr_src), 8'd0);
        checkOutput("rst alu_src_b", 8'(alu_src_b), 8'd2);
        checkOutput("rst result_src", 8'(result_src), 8'd2);
    endtask

    // One clock of stimulus: drive at negedge, check settled outputs, then
    // advance the model across the following rising edge.
    task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f3, input logic f75,
                                 input logic z, input logic l, input logic lu, input logic rdy);
        phase_t nxt;
        int cntNext, eReq, eWr, eIr, ePc, eReg, eIll, eTo, eAdr, eRes, eA, eB, eAlu;
        bit timeout;
        @(negedge clk);
        rst_n = 1'b1; op = o; funct3 = f3; funct7_5 = f75;
        zero = z; lt = l; ltu = lu; mem_ready = rdy;
        #1;
        {eReq, eWr, eIr, ePc, eReg, eIll, eTo} = '0;
        eAdr = -1; eRes = -1; eA = -1; eB = -1; eAlu = -1;
        nxt = phase;
        cntNext = 0;
        timeout = (WAIT_LIMIT > 0) && !rdy && (waitCount == WAIT_LIMIT);
        if (phase inside {P_FETCH, P_MEMREAD, P_MEMWRITE})
            cntNext = (rdy || timeout) ? 0 : waitCount + 1;
        case (phase)
            P_FETCH: begin
                eReq = 1; eAdr = 0; eA = 0; eB = 2; eAlu = 0; eRes = 2;
                if (rdy) begin eIr = 1; ePc = 1; nxt = P_DECODE; end
                else if (timeout) eTo = 1;
            end
            P_DECODE: begin
                eA = 1; eB = 1; eAlu = 0;
                if (o == LOAD || o == STORE) nxt = P_MEMADR;
                else if (o == RTYPE)         nxt = P_EXECR;
                else if (o == ITYPE)         nxt = P_EXECI;
                else if (o == BRANCH)        nxt = P_BRANCH;
                else if (o == JAL)           nxt = P_JAL;
                else                         nxt = P_ILLEGAL;
            end
            P_MEMADR: begin
                eA = 2; eB = 1; eAlu = 0;
                nxt = o[5] ? P_MEMWRITE : P_MEMREAD;
            end
            P_MEMREAD: begin
                eReq = 1; eAdr = 1; eRes = 0;
                if (rdy) nxt = P_MEMWB;
                else if (timeout) begin eTo = 1; nxt = P_FETCH; end
            end
            P_MEMWB:  begin eRes = 1; eReg = 1; nxt = P_FETCH; end
            P_MEMWRITE: begin
                eReq = 1; eWr = 1; eAdr = 1;
                if (rdy) nxt = P_FETCH;
                else if (timeout) begin eTo = 1; nxt = P_FETCH; end
            end
            P_EXECR:  begin eA = 2; eB = 0; eAlu = funcCode(o, f3, f75); nxt = P_ALUWB; end
            P_EXECI:  begin eA = 2; eB = 1; eAlu = funcCode(o, f3, f75); nxt = P_ALUWB; end
            P_ALUWB:  begin eRes = 0; eReg = 1; nxt = P_FETCH; end
            P_BRANCH: begin
                eA = 2; eB = 0; eAlu = 1; eRes = 0;
                ePc = int'(branchTaken(f3, z, l, lu));
                nxt = P_FETCH;
            end
            P_JAL:     begin eA = 1; eB = 2; eAlu = 0; eRes = 0; ePc = 1; nxt = P_ALUWB; end
            P_ILLEGAL: begin eIll = 1; nxt = P_FETCH; end
            default:   nxt = P_FETCH;
        endcase
        checkOutput("mem_req", 8'(mem_req), 8'(eReq));
        checkOutput("mem_write", 8'(mem_write), 8'(eWr));
        checkOutput("ir_write", 8'(ir_write), 8'(eIr));
        checkOutput("pc_write", 8'(pc_write), 8'(ePc));
        checkOutput("reg_write", 8'(reg_write), 8'(eReg));
        checkOutput("illegal_op", 8'(illegal_op), 8'(eIll));
        checkOutput("mem_timeout", 8'(mem_timeout), 8'(eTo));
        checkOutput("imm_src", 8'(imm_src), 8'(immOf(o)));
        if (eAdr >= 0) checkOutput("adr_src", 8'(adr_src), 8'(eAdr));
        if (eRes >= 0) checkOutput("result_src", 8'(result_src), 8'(eRes));
        if (eA >= 0)   checkOutput("alu_src_a", 8'(alu_src_a), 8'(eA));
        if (eB >= 0)   checkOutput("alu_src_b", 8'(alu_src_b), 8'(eB));
        if (eAlu >= 0) checkOutput("alu_control", 8'(alu_control), 8'(eAlu));
        @(posedge clk);
        phase = nxt;
        waitCount = cntNext;
    endtask

    initial begin
        logic [6:0] rop;
        int stallLeft = 0;
        rst_n = 1'b0; op = '0; funct3 = '0; funct7_5 = 1'b0;
        zero = 1'b0; lt = 1'b0; ltu = 1'b0; mem_ready = 1'b0;
        applyReset();

        // add, sub, addi with funct7_5 set
        repeat (4) applyStimulus(RTYPE, 3'd0, 1'b0, 0, 0, 0, 1);
        repeat (4) applyStimulus(RTYPE, 3'd0, 1'b1, 0, 0, 0, 1);
        repeat (4) applyStimulus(ITYPE, 3'd0, 1'b1, 0, 0, 0, 1);

        // lw stalled three cycles in MEMREAD
        repeat (3) applyStimulus(LOAD, 3'd2, 1'b0, 0, 0, 0, 1);
        repeat (3) applyStimulus(LOAD, 3'd2, 1'b0, 0, 0, 0, 0);
        repeat (2) applyStimulus(LOAD, 3'd2, 1'b0, 0, 0, 0, 1);

        // sw that never completes: timeout on the 16th wait cycle
        repeat (3) applyStimulus(STORE, 3'd2, 1'b0, 0, 0, 0, 1);
        repeat (19) applyStimulus(STORE, 3'd2, 1'b0, 0, 0, 0, 0);
        applyStimulus(STORE, 3'd2, 1'b0, 0, 0, 0, 1);

        // beq taken / not taken, bne with zero clear, illegal opcode
        repeat (3) applyStimulus(BRANCH, 3'd0, 1'b0, 1, 0, 0, 1);
        repeat (3) applyStimulus(BRANCH, 3'd0, 1'b0, 0, 0, 0, 1);
        repeat (3) applyStimulus(BRANCH, 3'd1, 1'b0, 0, 0, 0, 1);
        repeat (4) applyStimulus(LUI, 3'd0, 1'b0, 0, 0, 0, 1);
        repeat (4) applyStimulus(JAL, 3'd0, 1'b0, 0, 0, 0, 1);

        // reset while a store is waiting in MEMWRITE
        repeat (3) applyStimulus(STORE, 3'd2, 1'b0, 0, 0, 0, 1);
        repeat (2) applyStimulus(STORE, 3'd2, 1'b0, 0, 0, 0, 0);
        applyReset();
        repeat (4) applyStimulus(RTYPE, 3'd7, 1'b0, 0, 0, 0, 1);

        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 7))
                0: rop = LOAD;
                1: rop = STORE;
                2: rop = RTYPE;
                3: rop = ITYPE;
                4: rop = BRANCH;
                5: rop = JAL;
                6: rop = LUI;
                default: rop = 7'($urandom);
            endcase
            if (stallLeft == 0 && $urandom_range(0, 59) == 0) stallLeft = $urandom_range(14, 20);
            if ($urandom_range(0, 299) == 0) applyReset();
            applyStimulus(rop, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                          (stallLeft > 0) ? 1'b0 : 1'($urandom_range(0, 3) != 0));
            if (stallLeft > 0) stallLeft--;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Moore-style FSM controller for the multicycle RV32I datapath; successor to the single-cycle decoder.
- Sequences Fetch/Decode/Execute/Memory/Writeback over shared memory and ALU.
- Adds a memory ready handshake, a bounded-wait timeout, illegal-opcode signalling and an extended ALU op set.
- Sits between the instruction register/flags and the datapath mux/enable inputs.

Parameters:
- ALU_CTRL_W, 3: width of alu_control. Must be >= 3; bits above [2:0] are driven 0.
- WAIT_LIMIT, 15: maximum cycles spent waiting on mem_ready before timeout. 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- op  in  7  opcode from the instruction register
- funct3  in  3  instr[14:12]
- funct7_5  in  1  instr[30]
- zero  in  1  ALU zero flag (combinational, valid in BRANCH)
- lt  in  1  signed less-than flag (used only with BRANCH_EXT_EN)
- ltu  in  1  unsigned less-than flag (used only with BRANCH_EXT_EN)
- mem_ready  in  1  memory accepts write / returns read data this cycle
- mem_req  out  1  memory access request
- mem_write  out  1  memory write strobe
- adr_src  out  1  address select: 0 = PC, 1 = ALUOut
- ir_write  out  1  instruction register load
- pc_write  out  1  PC load
- reg_write  out  1  register file write
- result_src  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1
- alu_src_b  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = const 4
- imm_src  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- alu_control  out  ALU_CTRL_W  ALU function code
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- mem_timeout  out  1  one-cycle pulse when a wait expires

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset: state = FETCH, wait_cnt = 0.
  - While rst_n = 0, these outputs are 0: mem_req, mem_write, ir_write, pc_write, reg_write, illegal_op, mem_timeout.
  - Selects take their FETCH values.
- States, 4-bit encoding: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, ILLEGAL.
- FETCH: mem_req = 1, adr_src = 0, a = 00, b = 10, alu_op = ADD, result_src = 10.
  - On mem_ready: ir_write = 1, pc_write = 1, next state DECODE.
  - Otherwise hold FETCH.
- DECODE: a = 01, b = 01, ADD (branch target into ALUOut). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - any other -> ILLEGAL
- MEMADR: a = 10, b = 01, ADD. Next state MEMREAD if op[5] = 0, else MEMWRITE.
- MEMREAD: mem_req = 1, adr_src = 1, result_src = 00. Leaves to MEMWB on mem_ready.
- MEMWB: result_src = 01, reg_write = 1. Next state FETCH.
- MEMWRITE: mem_req = 1, mem_write = 1, adr_src = 1. Leaves to FETCH on mem_ready.
- EXECR: a = 10, b = 00, alu_op = FUNC. Next state ALUWB.
- EXECI: a = 10, b = 01, alu_op = FUNC. Next state ALUWB.
- ALUWB: result_src = 00, reg_write = 1. Next state FETCH.
- BRANCH: a = 10, b = 00, SUB, result_src = 00.
  - pc_write = 1 when the branch is taken.
  - Next state FETCH.
- JAL: a = 01, b = 10, ADD, result_src = 00, pc_write = 1. Next state ALUWB (writes PC+4 to rd).
- ILLEGAL: illegal_op = 1 for one cycle, no write enables. Next state FETCH (PC already advanced).
- imm_src is decoded from op in every state:
  - 0100011 -> 01
  - 1100011 -> 10
  - 1101111 -> 11
  - else 00
- ALU codes for FUNC, selected by funct3:
  - 000: ADD, or SUB when op[5] & funct7_5
  - 001: SLL
  - 010: SLT
  - 100: XOR
  - 101: SRL
  - 110: OR
  - 111: AND
  - 011: ADD
  - Code values: ADD = 000, SUB = 001, AND = 010, OR = 011, XOR = 100, SLT = 101, SLL = 110, SRL = 111.
- Wait counter:
  - Increments each cycle in a wait state (FETCH, MEMREAD, MEMWRITE) while mem_ready = 0.
  - Clears on state exit or on mem_ready.
  - If WAIT_LIMIT > 0 and wait_cnt == WAIT_LIMIT with mem_ready still 0: mem_timeout pulses.
    - FETCH re-enters FETCH with the counter cleared.
    - MEMREAD and MEMWRITE abort to FETCH with no reg_write and no extra mem_write.
  - mem_ready on the same cycle as the limit: the access completes and there is no timeout.
- Reset asserted mid-operation: the FSM returns to FETCH immediately and enables drop the same instant.

Optional Feature:
- Macro BRANCH_EXT_EN defined: taken is selected by funct3.
  - 000 = zero, 001 = !zero
  - 100 = lt, 101 = !lt
  - 110 = ltu, 111 = !ltu
  - 010 and 011 = not taken
- Macro not defined: taken = zero for every funct3 (beq only); lt and ltu are ignored.

Decomposition:
- Package ctrl_pkg holds:
  - the state encoding
  - alu_op codes: ADD = 00, SUB = 01, FUNC = 10
  - ALU control codes
  - opcode constants
  - select-value constants for result_src, alu_src_a, alu_src_b and imm_src
- One sub-module, mc_alu_dec: combinational alu_op/funct3/funct7_5/op[5] -> alu_control.

Test Plan:
- add x3,x1,x2 (op 0110011, f3 000, f7_5 0), mem_ready = 1 -> FETCH, DECODE, EXECR (alu_control = 000), ALUWB (reg_write = 1); 4 cycles total.
- sub variant, f7_5 = 1 -> alu_control = 001 in EXECR; addi with f7_5 = 1 -> 000.
- lw with mem_ready held low 3 cycles in MEMREAD -> mem_req = 1 for 4 cycles, then MEMWB with result_src = 01 and reg_write = 1.
- sw with mem_ready never high, WAIT_LIMIT = 15 -> mem_timeout pulses on wait cycle 16 (wait_cnt == 15), next state FETCH, mem_write deasserted afterwards.
- beq with zero = 1 -> pc_write = 1 in BRANCH; zero = 0 -> pc_write = 0.
  - With BRANCH_EXT_EN: f3 001 with zero = 0 -> pc_write = 1.
- op 0110111 -> ILLEGAL with a 1-cycle illegal_op pulse, then FETCH.
  - rst_n pulsed low in MEMWRITE -> mem_write = 0 at once and state FETCH after release.
